// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter for the shared global-memory port: one grantee at a time, held until ack or abort.
// Optional forced release after MAX_HOLD cycles is built when the ARB_TIMEOUT_EN macro is defined.
module mem_rr_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int MAX_HOLD  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          request,
    input  logic                          mem_ack,
    output logic [NUM_CORES-1:0]          core_select,
    output logic [$clog2(NUM_CORES)-1:0]  grant_id,
    output logic                          grant_valid,
    output logic                          timeout_pulse
);

    localparam int ID_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NUM_CORES-1:0]   r_core_select;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        r_last_id;
    logic                   r_grant_valid;
    logic                   r_pulse;
    logic                   w_found;
    logic [ID_W-1:0]        w_pick_id;
    logic [ID_W-1:0]        w_scan;
    logic                   w_grant_live;
    logic                   w_timeout;

    assign w_grant_live = request[r_grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] r_hold;

    // Counter sits at zero through IDLE, so it is clear on the first GRANT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold <= '0;
        end else if (r_state == S_IDLE) begin
            r_hold <= '0;
        end else if (r_state == S_GRANT) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign w_timeout = (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Scan starts one past the last owner; the power-of-two width makes the wrap free.
    always_comb begin
        w_found   = 1'b0;
        w_pick_id = '0;
        w_scan    = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_scan = r_last_id + k[ID_W-1:0];
            if (!w_found && request[w_scan]) begin
                w_found   = 1'b1;
                w_pick_id = w_scan;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next_state = S_GRANT;
            S_GRANT:   if (mem_ack || !w_grant_live || w_timeout) w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_core_select <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_last_id     <= '1;
            r_pulse       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_core_select <= NUM_CORES'(1) << w_pick_id;
                        r_grant_id    <= w_pick_id;
                        r_grant_valid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_next_state == S_RELEASE) begin
                        r_core_select <= '0;
                        r_grant_valid <= 1'b0;
                        r_last_id     <= r_grant_id;
                        // An ack arriving on the limit cycle is an ordinary completion.
                        r_pulse       <= w_timeout && !mem_ack;
                    end
                end
                default: begin
                    r_core_select <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        core_select   = r_core_select;
        grant_id      = r_grant_id;
        grant_valid   = r_grant_valid;
        timeout_pulse = r_pulse;
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed stimulus, a per-cycle ownership model and literal spot checks.
module tb_mem_rr_arbiter;

    localparam int N        = 16;
    localparam int IW       = 4;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          mem_ack = 1'b0;
    logic [N-1:0]  request = '0;
    logic [N-1:0]  core_select;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          timeout_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.NUM_CORES(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .reset         (reset),
        .request       (request),
        .mem_ack       (mem_ack),
        .core_select   (core_select),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .timeout_pulse (timeout_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the port, how many turnaround cycles remain, who was served last.
    int            m_owner = -1;
    int            m_gap   = 0;
    int            m_last  = N - 1;
    int            m_hold  = 0;
    logic [IW-1:0] m_gid   = '0;
    bit            m_pulse = 1'b0;
    bit            m_init  = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_owner = -1;
            m_gap   = 0;
            m_last  = N - 1;
            m_hold  = 0;
            m_gid   = '0;
            m_pulse = 1'b0;
            m_init  = 1'b1;
        end else begin
            m_pulse = 1'b0;
            if (m_owner >= 0) begin
                bit lim;
                lim = TO_EN && (m_hold == MAX_HOLD - 1);
                if (mem_ack || !request[m_owner] || lim) begin
                    m_pulse = lim && !mem_ack;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_gap   = 1;
                end else begin
                    m_hold++;
                end
            end else if (m_gap > 0) begin
                m_gap = 0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (m_owner < 0 && request[c]) begin
                        m_owner = c;
                        m_gid   = c[IW-1:0];
                        m_hold  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("mdl_core_select", core_select, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("mdl_grant_id", grant_id, m_gid);
            check("mdl_grant_valid", grant_valid, (m_owner >= 0) ? 32'd1 : 32'd0);
            check("mdl_timeout_pulse", timeout_pulse, m_pulse);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(output int id);
        bit ok;
        ok = 1'b0;
        id = -1;
        for (int i = 0; i < 40; i++) begin
            if (grant_valid) begin
                ok = 1'b1;
                id = int'(grant_id);
                break;
            end
            tick;
        end
        check("wait_grant", ok, 1);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        reset = 1'b1;
    endtask

    initial begin
        int id;
        int cnt;

        // Reset held with every core requesting
        request = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rst_core_select", core_select, 0);
            check("rst_grant_valid", grant_valid, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_pulse", timeout_pulse, 0);
        end

        // Lone requester, ack together with request drop
        request = 16'h0001;
        reset   = 1'b1;
        tick;
        check("single_sel", core_select, 16'h0001);
        check("single_id", grant_id, 0);
        mem_ack = 1'b1;
        request = 16'h0000;
        tick;
        mem_ack = 1'b0;
        check("single_release", core_select, 0);
        check("single_release_gid", grant_id, 0);
        tick;
        check("single_idle", grant_valid, 0);

        // Full rotation with every core requesting
        do_reset;
        request = 16'hFFFF;
        for (int k = 0; k <= N; k++) begin
            wait_grant(id);
            check("rr_seq", id, k % N);
            tick;
            mem_ack = 1'b1;
            tick;
            mem_ack = 1'b0;
        end
        request = 16'h0000;
        tick;
        tick;

        // Wrap past cores 4..15 after serving core 3
        do_reset;
        request = 16'h0008;
        wait_grant(id);
        check("wrap_first", id, 3);
        mem_ack = 1'b1;
        request = 16'h0005;
        tick;
        mem_ack = 1'b0;
        wait_grant(id);
        check("wrap_core0", id, 0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        wait_grant(id);
        check("wrap_core2", id, 2);
        mem_ack = 1'b1;
        request = 16'h0000;
        tick;
        mem_ack = 1'b0;
        tick;

        // Requester abort releases without a timeout pulse; next owner follows core 5
        do_reset;
        request = 16'h0020;
        wait_grant(id);
        check("abort_grant", id, 5);
        request = 16'h0000;
        tick;
        check("abort_release", grant_valid, 0);
        check("abort_pulse", timeout_pulse, 0);
        request = 16'hFFFF;
        wait_grant(id);
        check("abort_next", id, 6);
        mem_ack = 1'b1;
        request = 16'h0000;
        tick;
        mem_ack = 1'b0;
        tick;

        do_reset;
        request = 16'h0020;
        wait_grant(id);
        check("hold_grant", id, 5);
`ifdef ARB_TIMEOUT_EN
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (!grant_valid) break;
            cnt++;
        end
        check("to_grant_cycles", cnt, MAX_HOLD);
        check("to_pulse_high", timeout_pulse, 1);
        tick;
        check("to_pulse_low", timeout_pulse, 0);
        wait_grant(id);
        check("to_regrant", id, 5);
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (grant_valid) cnt++;
        end
        check("hold_cycles", cnt, 100);
        check("hold_sel", core_select, 16'h0020);
        check("hold_no_pulse", timeout_pulse, 0);
`endif

        // Reset in the middle of a grant
        reset = 1'b0;
        tick;
        check("midrst_sel", core_select, 0);
        check("midrst_valid", grant_valid, 0);
        check("midrst_gid", grant_id, 0);
        reset   = 1'b1;
        request = 16'h0000;
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
